// File: rtl/spram_pkg.sv
// Shared types and constants for the SB_SPRAM256KA front end.
package spram_pkg;

  typedef enum logic [1:0] {IDLE, STANDBY, SLEEP, WAKE} pwr_state_e;

  localparam int SPRAM_AW = 14;
  localparam int SPRAM_DW = 16;

  // MASKWREN enables one nibble per bit, so each byte enable covers two bits.
  function automatic logic [3:0] be_to_maskwren(input logic [1:0] be);
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/spram_pwr_fsm.sv
// Power-mode sequencer: IDLE/STANDBY/SLEEP/WAKE, idle and wake counters,
// request gating and the shared STANDBY/SLEEP pins.
module spram_pwr_fsm
  import spram_pkg::*;
#(
  parameter int IDLE_CYCLES  = 64,
  parameter int STANDBY_WAKE = 1,
  parameter int SLEEP_WAKE   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic accept_i,
  input  logic rsp_pend_i,
  input  logic sleep_req_i,
  output logic req_ready_o,
  output logic standby_o,
  output logic sleep_o
);

  localparam int IW    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int MAXW  = (STANDBY_WAKE > SLEEP_WAKE) ? STANDBY_WAKE : SLEEP_WAKE;
  localparam int WW    = $clog2(MAXW + 1);
  localparam bit AUTO_SB = (IDLE_CYCLES > 0);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = (IDLE_CYCLES > 0) ? IW'(IDLE_CYCLES - 1) : '0;
  localparam logic [WW-1:0] SB_WAKE_C = WW'(STANDBY_WAKE);
  localparam logic [WW-1:0] SL_WAKE_C = WW'(SLEEP_WAKE);

  if (IDLE_CYCLES < 0 || STANDBY_WAKE < 1 || SLEEP_WAKE < 1) begin : g_bad_timing
    $fatal(1, "spram_pwr_fsm: illegal IDLE_CYCLES/STANDBY_WAKE/SLEEP_WAKE");
  end

  pwr_state_e      state_q, state_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]   wake_cnt_q, wake_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    req_ready_o = 1'b0;
    standby_o   = 1'b0;
    sleep_o     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !sleep_req_i;
        if (accept_i)                  idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
        // A read response in flight finishes before the banks are put to sleep.
        if (sleep_req_i && !rsp_pend_i)
          state_d = SLEEP;
        else if (AUTO_SB && !accept_i && idle_cnt_q == IDLE_LAST)
          state_d = STANDBY;
      end
      STANDBY: begin
        standby_o = 1'b1;
        if (sleep_req_i) begin
          state_d = SLEEP;
        end else if (req_valid_i) begin
          state_d    = WAKE;
          wake_cnt_d = SB_WAKE_C;
        end
      end
      SLEEP: begin
        sleep_o = 1'b1;
        if (!sleep_req_i) begin
          state_d    = WAKE;
          wake_cnt_d = SL_WAKE_C;
        end
      end
      WAKE: begin
        if (sleep_req_i) begin
          state_d = SLEEP;
        end else if (wake_cnt_q <= WW'(1)) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/spram_ctrl.sv
// Valid/ready front end for NUM_BANKS SB_SPRAM256KA: bank decode, pin drive,
// 1-cycle read response, and low-power sequencing via spram_pwr_fsm.
module spram_ctrl
  import spram_pkg::*;
#(
  parameter int NUM_BANKS    = 2,
  parameter int IDLE_CYCLES  = 64,
  parameter int STANDBY_WAKE = 1,
  parameter int SLEEP_WAKE   = 4,
  localparam int ADDR_W      = SPRAM_AW + $clog2(NUM_BANKS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_we,
  input  logic [1:0]                    req_be,
  input  logic [SPRAM_DW-1:0]           req_wdata,
  output logic                          rsp_valid,
  output logic [SPRAM_DW-1:0]           rsp_rdata,
  input  logic                          sleep_req,
  output logic [SPRAM_AW-1:0]           spram_addr,
  output logic [SPRAM_DW-1:0]           spram_datain,
  output logic [3:0]                    spram_maskwren,
  output logic                          spram_wren,
  output logic [NUM_BANKS-1:0]          spram_cs,
  output logic                          spram_standby,
  output logic                          spram_sleep,
  output logic                          spram_poweroff,
  input  logic [SPRAM_DW*NUM_BANKS-1:0] spram_dataout
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : g_bad_banks
    $fatal(1, "spram_ctrl: NUM_BANKS must be 1, 2 or 4");
  end

  logic                accept;
  logic [BANK_W-1:0]   bank;
  logic [BANK_W-1:0]   bank_q;
  logic                rsp_valid_q;
  logic [SPRAM_DW-1:0] rdata_hold_q;
  logic [SPRAM_DW-1:0] rd_word;

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank = req_addr[ADDR_W-1:SPRAM_AW];
  end else begin : g_one_bank
    assign bank = '0;
  end

  assign accept = req_valid & req_ready;

  spram_pwr_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .STANDBY_WAKE(STANDBY_WAKE),
    .SLEEP_WAKE  (SLEEP_WAKE)
  ) u_pwr (
    .clk_i      (clock),
    .rst_i      (reset),
    .req_valid_i(req_valid),
    .accept_i   (accept),
    .rsp_pend_i (rsp_valid_q),
    .sleep_req_i(sleep_req),
    .req_ready_o(req_ready),
    .standby_o  (spram_standby),
    .sleep_o    (spram_sleep)
  );

  assign spram_addr     = req_addr[SPRAM_AW-1:0];
  assign spram_datain   = req_wdata;
  assign spram_maskwren = be_to_maskwren(req_be);
  assign spram_wren     = accept & req_we;
  assign spram_poweroff = 1'b1;

  always_comb begin
    spram_cs = '0;
    if (accept) spram_cs[bank] = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BANK_W'(b)) rd_word = spram_dataout[b*SPRAM_DW +: SPRAM_DW];
    end
  end

  // DATAOUT is only valid in the cycle after the read, so it is captured then and held.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      bank_q       <= '0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q <= accept & ~req_we;
      if (accept)      bank_q       <= bank;
      if (rsp_valid_q) rdata_hold_q <= rd_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_valid_q ? rd_word : rdata_hold_q;

endmodule
